// File: rtl/modn_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : modn_counter_if
// Description : Control/status bundle for modn_counter. The master side drives
//               the count controls and observes count, BCD digits and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface modn_counter_if #(
    parameter int WIDTH = 6
);
    logic             tick;
    logic             keep;
    logic             adj_up;
    logic             adj_down;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic [3:0]       tens;
    logic [3:0]       ones;
    logic             carry;
    logic             is_zero;

    modport master (
        output tick, keep, adj_up, adj_down, load, load_val,
        input  count, tens, ones, carry, is_zero
    );

    modport slave (
        input  tick, keep, adj_up, adj_down, load, load_val,
        output count, tens, ones, carry, is_zero
    );
endinterface : modn_counter_if
`default_nettype wire

// File: rtl/modn_counter.sv
`default_nettype none
// ============================================================================
// Module      : modn_counter
// Description : Modulo-N counter with tick-driven count and carry, synchronous
//               load/hold, push-button +1/-1 adjust with edge detection, and
//               registered BCD tens/ones digits that track the binary count.
// Revision    : 1.0 - initial release
// ============================================================================
module modn_counter #(
    parameter int MODULUS = 24,
    parameter int WIDTH   = 6
) (
    input  logic           clk,
    input  logic           clear,
    modn_counter_if.slave  bus
);
    // Wrap points are found by comparing against the terminal value, so a
    // modulus that is not a power of two never relies on natural overflow.
    localparam logic [WIDTH-1:0] c_max = WIDTH'(MODULUS - 1);

    logic             up_s1_q,   up_s1_d;
    logic             up_s2_q,   up_s2_d;
    logic             up_hist_q, up_hist_d;
    logic             dn_s1_q,   dn_s1_d;
    logic             dn_s2_q,   dn_s2_d;
    logic             dn_hist_q, dn_hist_d;
    logic [WIDTH-1:0] count_q,   count_d;
    logic [3:0]       tens_q,    tens_d;
    logic [3:0]       ones_q,    ones_d;
    logic             carry_q,   carry_d;
    logic             up_evt;
    logic             dn_evt;

    // Next-state: synchronize buttons, detect presses, then resolve
    // load > keep > adjust > tick; digits are derived from the next count.
    always_comb begin
        up_s1_d   = bus.adj_up;
        up_s2_d   = up_s1_q;
        up_hist_d = up_s2_q;
        dn_s1_d   = bus.adj_down;
        dn_s2_d   = dn_s1_q;
        dn_hist_d = dn_s2_q;

        // A press lasts exactly one cycle; if load or keep wins that cycle the
        // event is simply lost because history catches up on the next edge.
        up_evt = up_s2_q & ~up_hist_q;
        dn_evt = dn_s2_q & ~dn_hist_q;

        count_d = count_q;
        carry_d = 1'b0;

        if (bus.load) begin
            // Out-of-range load values collapse to zero so count stays legal.
            count_d = (32'(bus.load_val) < MODULUS) ? bus.load_val : '0;
        end else if (bus.keep) begin
            count_d = count_q;
        end else if (up_evt || dn_evt) begin
            // Simultaneous up and down cancel; any tick this cycle is dropped.
            if (up_evt && !dn_evt) begin
                count_d = (count_q == c_max) ? '0 : count_q + 1'b1;
            end else if (dn_evt && !up_evt) begin
                count_d = (count_q == '0) ? c_max : count_q - 1'b1;
            end
        end else if (bus.tick) begin
            if (count_q == c_max) begin
                count_d = '0;
                carry_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end

        tens_d = 4'(32'(count_d) / 10);
        ones_d = 4'(32'(count_d) % 10);
    end

    // State register; clear forces everything, including synchronizers, idle.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            up_s1_q   <= 1'b0;
            up_s2_q   <= 1'b0;
            up_hist_q <= 1'b0;
            dn_s1_q   <= 1'b0;
            dn_s2_q   <= 1'b0;
            dn_hist_q <= 1'b0;
            count_q   <= '0;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            carry_q   <= 1'b0;
        end else begin
            up_s1_q   <= up_s1_d;
            up_s2_q   <= up_s2_d;
            up_hist_q <= up_hist_d;
            dn_s1_q   <= dn_s1_d;
            dn_s2_q   <= dn_s2_d;
            dn_hist_q <= dn_hist_d;
            count_q   <= count_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            carry_q   <= carry_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.tens    = tens_q;
    assign bus.ones    = ones_q;
    assign bus.carry   = carry_q;
    assign bus.is_zero = (count_q == '0);

endmodule : modn_counter
`default_nettype wire

// File: tb/tb_modn_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_modn_counter
// Description : Directed self-checking bench for modn_counter (MODULUS=24 and
//               MODULUS=60 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modn_counter;

    logic clk;
    logic clear;
    int   checks;
    int   errors;

    modn_counter_if #(.WIDTH(6)) ifa ();
    modn_counter_if #(.WIDTH(6)) ifb ();

    modn_counter #(.MODULUS(24), .WIDTH(6)) u_dut_a (
        .clk   (clk),
        .clear (clear),
        .bus   (ifa)
    );

    modn_counter #(.MODULUS(60), .WIDTH(6)) u_dut_b (
        .clk   (clk),
        .clear (clear),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input int c, input logic cy);
        check({tag, ".count"}, 32'(ifa.count), 32'(c));
        check({tag, ".tens"},  32'(ifa.tens),  32'(c / 10));
        check({tag, ".ones"},  32'(ifa.ones),  32'(c % 10));
        check({tag, ".carry"}, 32'(ifa.carry), 32'(cy));
    endtask

    task automatic load_a(input logic [5:0] v);
        ifa.load_val = v;
        ifa.load     = 1'b1;
        cyc();
        ifa.load     = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear  = 1'b1;
        ifa.tick = 0; ifa.keep = 0; ifa.adj_up = 0; ifa.adj_down = 0; ifa.load = 0; ifa.load_val = '0;
        ifb.tick = 0; ifb.keep = 0; ifb.adj_up = 0; ifb.adj_down = 0; ifb.load = 0; ifb.load_val = '0;

        // Reset state, with tick asserted to show inputs are ignored under clear
        ifa.tick = 1'b1;
        cyc(); cyc();
        check_a("reset", 0, 1'b0);
        check("reset.is_zero", 32'(ifa.is_zero), 32'd1);
        ifa.tick = 1'b0;
        clear = 1'b0;

        // 24 consecutive ticks: 1..23 then 0 with carry on the wrap only
        for (int i = 1; i <= 24; i++) begin
            ifa.tick = 1'b1;
            cyc();
            check_a("tick_seq", i % 24, (i == 24));
        end
        ifa.tick = 1'b0;
        cyc();
        check_a("carry_one_cycle", 0, 1'b0);

        // Adjust up from 23, held 10 cycles: one wrap to 0 on 3rd edge, no carry
        load_a(6'd23);
        check_a("load23", 23, 1'b0);
        ifa.adj_up = 1'b1;
        cyc(); check_a("adj_up.e1", 23, 1'b0);
        cyc(); check_a("adj_up.e2", 23, 1'b0);
        cyc(); check_a("adj_up.e3", 0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cyc();
            check_a("adj_up.hold", 0, 1'b0);
        end
        ifa.adj_up = 1'b0;
        cyc(); cyc(); cyc();

        // Adjust down from 0 wraps to 23
        ifa.adj_down = 1'b1;
        cyc(); cyc();
        check_a("adj_dn.e2", 0, 1'b0);
        cyc();
        check_a("adj_dn.e3", 23, 1'b0);
        ifa.adj_down = 1'b0;
        cyc(); cyc(); cyc();
        check_a("adj_dn.after", 23, 1'b0);

        // Up and down pressed together cancel
        load_a(6'd5);
        ifa.adj_up   = 1'b1;
        ifa.adj_down = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        check_a("up_dn_cancel", 5, 1'b0);
        ifa.adj_up   = 1'b0;
        ifa.adj_down = 1'b0;
        cyc(); cyc(); cyc();

        // Adjust event coincident with tick: adjust wins, tick dropped
        ifa.adj_up = 1'b1;
        cyc(); cyc();
        ifa.tick = 1'b1;
        cyc();
        ifa.tick = 1'b0;
        check_a("adj_tick.same", 6, 1'b0);
        cyc();
        check_a("adj_tick.after", 6, 1'b0);
        ifa.adj_up = 1'b0;
        cyc(); cyc(); cyc();

        // Loads: in-range, out-of-range, and load beating keep
        load_a(6'd17);
        check_a("load17", 17, 1'b0);
        load_a(6'd30);
        check_a("load30", 0, 1'b0);
        check("load30.is_zero", 32'(ifa.is_zero), 32'd1);
        ifa.keep = 1'b1;
        load_a(6'd12);
        check_a("load_over_keep", 12, 1'b0);

        // Keep holds through ticks and a button press
        ifa.tick   = 1'b1;
        ifa.adj_up = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        check_a("keep.hold", 12, 1'b0);
        ifa.tick   = 1'b0;
        ifa.adj_up = 1'b0;
        cyc(); cyc();
        ifa.keep = 1'b0;
        cyc();
        check_a("keep.release", 12, 1'b0);
        ifa.tick = 1'b1;
        cyc();
        ifa.tick = 1'b0;
        check_a("keep.then_tick", 13, 1'b0);

        // Asynchronous clear before the wrapping edge
        load_a(6'd23);
        ifa.tick = 1'b1;
        #2 clear = 1'b1;
        #1;
        check_a("async_clear", 0, 1'b0);
        check("async_clear.is_zero", 32'(ifa.is_zero), 32'd1);
        cyc();
        check_a("clear_held", 0, 1'b0);
        clear = 1'b0;
        ifa.tick = 1'b0;

        // Clear while carry is high drops it immediately
        load_a(6'd23);
        ifa.tick = 1'b1;
        cyc();
        ifa.tick = 1'b0;
        check_a("carry_before_clear", 0, 1'b1);
        #2 clear = 1'b1;
        #1;
        check("clear_mid_carry", 32'(ifa.carry), 32'd0);

        // Button held across clear release yields exactly one step
        ifa.adj_up = 1'b1;
        cyc();
        clear = 1'b0;
        cyc(); cyc();
        check_a("btn_across_clear.e2", 0, 1'b0);
        cyc();
        check_a("btn_across_clear.e3", 1, 1'b0);
        cyc(); cyc(); cyc();
        check_a("btn_across_clear.once", 1, 1'b0);
        ifa.adj_up = 1'b0;

        // MODULUS=60 instance wraps 59 -> 0 with carry
        ifb.load_val = 6'd59;
        ifb.load     = 1'b1;
        cyc();
        ifb.load     = 1'b0;
        check("m60.load59", 32'(ifb.count), 32'd59);
        check("m60.tens", 32'(ifb.tens), 32'd5);
        check("m60.ones", 32'(ifb.ones), 32'd9);
        ifb.tick = 1'b1;
        cyc();
        ifb.tick = 1'b0;
        check("m60.wrap", 32'(ifb.count), 32'd0);
        check("m60.carry", 32'(ifb.carry), 32'd1);
        cyc();
        check("m60.carry_low", 32'(ifb.carry), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_modn_counter
`default_nettype wire
